// File: rtl/isp1362_bus_pkg.sv
// Shared types and constants for the ISP1362 parallel-bus arbiter.
// Counter width, default bus timing, A1 channel encodings and FSM states.
package isp1362_bus_pkg;

    localparam int CNT_W = 8;

    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_STROBE_CYC  = 4;
    localparam int DEF_HOLD_CYC    = 1;
    localparam int DEF_RECOVER_CYC = 6;

    // A1 selects the controller half of the chip
    localparam logic A1_HC = 1'b0;
    localparam logic A1_DC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_e;

    typedef struct packed {
        logic ch;
        logic write;
    } cmd_t;

    function automatic logic [CNT_W-1:0] cnt_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/isp1362_rr_arb.sv
// Two-way round-robin arbiter: on contention the channel that did not win
// last time is granted. Grants are only issued while enabled.
module isp1362_rr_arb (
    input  logic en,
    input  logic v0,
    input  logic v1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    assign grant0 = en && v0 && (!v1 || last_grant);
    assign grant1 = en && v1 && (!v0 || !last_grant);

endmodule

// File: rtl/isp1362_bus_arbiter.sv
// Shares the ISP1362 16-bit bus between the HC (ch0) and DC (ch1) requesters,
// turning each accepted command into one timed CS/RD/WR bus cycle.
module isp1362_bus_arbiter
    import isp1362_bus_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int STROBE_CYC  = DEF_STROBE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        c0_valid,
    input  logic        c1_valid,
    input  logic        c0_write,
    input  logic        c1_write,
    input  logic        c0_a0,
    input  logic        c1_a0,
    input  logic [15:0] c0_wdata,
    input  logic [15:0] c1_wdata,
    output logic        c0_ready,
    output logic        c1_ready,
    output logic        c0_rsp_valid,
    output logic        c1_rsp_valid,
    output logic [15:0] c0_rdata,
    output logic [15:0] c1_rdata,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_dout,
    output logic        otg_doe,
    input  logic [15:0] otg_din
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_t             cmd_q, cmd_d;
    logic             last_grant_q, last_grant_d;
    logic             cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic [1:0]       addr_q, addr_d;
    logic [15:0]      dout_q, dout_d;
    logic             doe_q, doe_d;
    logic             rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    logic [15:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic             grant0, grant1;
    logic             cnt_zero;
    logic             acc_write, acc_a0;
    logic [15:0]      acc_wdata;

    isp1362_rr_arb u_arb (
        .en         (state_q == ST_IDLE),
        .v0         (c0_valid),
        .v1         (c1_valid),
        .last_grant (last_grant_q),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign c0_ready  = grant0;
    assign c1_ready  = grant1;
    assign cnt_zero  = (cnt_q == '0);
    assign acc_write = grant1 ? c1_write : c0_write;
    assign acc_a0    = grant1 ? c1_a0    : c0_a0;
    assign acc_wdata = grant1 ? c1_wdata : c0_wdata;

    // Next-state and next-output are computed together so every pin is a flop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (state_q == ST_IDLE) ? cnt_q : cnt_q - CNT_W'(1);
        cmd_d        = cmd_q;
        last_grant_d = last_grant_q;
        cs_n_d       = cs_n_q;
        rd_n_d       = rd_n_q;
        wr_n_d       = wr_n_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        doe_d        = doe_q;
        rsp0_d       = 1'b0;
        rsp1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    cmd_d.ch     = grant1 ? A1_DC : A1_HC;
                    cmd_d.write  = acc_write;
                    last_grant_d = grant1;
                    state_d      = ST_SETUP;
                    cnt_d        = cnt_load(SETUP_CYC);
                    cs_n_d       = 1'b0;
                    addr_d       = {cmd_d.ch, acc_a0};
                    if (acc_write) begin
                        doe_d  = 1'b1;
                        dout_d = acc_wdata;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_STROBE;
                    cnt_d   = cnt_load(STROBE_CYC);
                    rd_n_d  = cmd_q.write;
                    wr_n_d  = !cmd_q.write;
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_load(HOLD_CYC);
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    rsp0_d  = !cmd_q.ch;
                    rsp1_d  = cmd_q.ch;
                    if (!cmd_q.write) begin
                        if (cmd_q.ch) rdata1_d = otg_din;
                        else          rdata0_d = otg_din;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_RECOVER;
                    cnt_d   = cnt_load(RECOVER_CYC);
                    cs_n_d  = 1'b1;
                    doe_d   = 1'b0;
                end
            end
            ST_RECOVER: begin
                if (cnt_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_q        <= '0;
            last_grant_q <= 1'b1;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            addr_q       <= '0;
            dout_q       <= '0;
            doe_q        <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            last_grant_q <= last_grant_d;
            cs_n_q       <= cs_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            doe_q        <= doe_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign otg_cs_n     = cs_n_q;
    assign otg_rd_n     = rd_n_q;
    assign otg_wr_n     = wr_n_q;
    assign otg_addr     = addr_q;
    assign otg_dout     = dout_q;
    assign otg_doe      = doe_q;
    assign c0_rsp_valid = rsp0_q;
    assign c1_rsp_valid = rsp1_q;
    assign c0_rdata     = rdata0_q;
    assign c1_rdata     = rdata1_q;

endmodule

// File: tb/tb_isp1362_bus_arbiter.sv
// Bench for isp1362_bus_arbiter: default-timing and short-timing instances,
// directed commands, a response scoreboard and per-cycle bus waveform checks.
module tb_isp1362_bus_arbiter;

    typedef struct {
        int          cyc;
        bit          ch;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          viol = 0;
    exp_t        sbq0[$];
    exp_t        sbq1[$];

    logic        rstn [2];
    logic [1:0]  vld [2];
    logic [1:0]  wrb [2];
    logic [1:0]  a0s [2];
    logic [15:0] wds [2][2];
    logic [15:0] din_s [2];
    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rsp0 [2];
    logic        rsp1 [2];
    logic [15:0] rdat0 [2];
    logic [15:0] rdat1 [2];
    logic [1:0]  addr [2];
    logic        cs_n [2];
    logic        rd_n [2];
    logic        wr_n [2];
    logic [15:0] dout [2];
    logic        doe [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    isp1362_bus_arbiter u_dut0 (
        .CLOCK_50(clk), .rst_n(rstn[0]),
        .c0_valid(vld[0][0]), .c1_valid(vld[0][1]),
        .c0_write(wrb[0][0]), .c1_write(wrb[0][1]),
        .c0_a0(a0s[0][0]), .c1_a0(a0s[0][1]),
        .c0_wdata(wds[0][0]), .c1_wdata(wds[0][1]),
        .c0_ready(rdy0[0]), .c1_ready(rdy1[0]),
        .c0_rsp_valid(rsp0[0]), .c1_rsp_valid(rsp1[0]),
        .c0_rdata(rdat0[0]), .c1_rdata(rdat1[0]),
        .otg_addr(addr[0]), .otg_cs_n(cs_n[0]), .otg_rd_n(rd_n[0]), .otg_wr_n(wr_n[0]),
        .otg_dout(dout[0]), .otg_doe(doe[0]), .otg_din(din_s[0])
    );

    isp1362_bus_arbiter #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .RECOVER_CYC(1)) u_dut1 (
        .CLOCK_50(clk), .rst_n(rstn[1]),
        .c0_valid(vld[1][0]), .c1_valid(vld[1][1]),
        .c0_write(wrb[1][0]), .c1_write(wrb[1][1]),
        .c0_a0(a0s[1][0]), .c1_a0(a0s[1][1]),
        .c0_wdata(wds[1][0]), .c1_wdata(wds[1][1]),
        .c0_ready(rdy0[1]), .c1_ready(rdy1[1]),
        .c0_rsp_valid(rsp0[1]), .c1_rsp_valid(rsp1[1]),
        .c0_rdata(rdat0[1]), .c1_rdata(rdat1[1]),
        .otg_addr(addr[1]), .otg_cs_n(cs_n[1]), .otg_rd_n(rd_n[1]), .otg_wr_n(wr_n[1]),
        .otg_dout(dout[1]), .otg_doe(doe[1]), .otg_din(din_s[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int p_s(input int d); return d == 0 ? 1 : 2; endfunction
    function automatic int p_t(input int d); return d == 0 ? 4 : 1; endfunction
    function automatic int p_h(input int d); return d == 0 ? 1 : 3; endfunction
    function automatic int p_r(input int d); return d == 0 ? 6 : 1; endfunction

    task automatic push_exp(input int d, input int at, input bit ch, input bit rd, input logic [15:0] data);
        exp_t e;
        e.cyc = at; e.ch = ch; e.rd = rd; e.data = data;
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    // One command from an idle DUT, checking every bus cycle of the transfer.
    task automatic issue(input int d, input bit ch, input bit wr, input bit a0,
                         input logic [15:0] wd, input logic [15:0] din, input int pulse_at);
        int s, t, h, occ;
        bit in_act, strobe;
        logic [7:0] exp_v, act_v;
        s = p_s(d); t = p_t(d); h = p_h(d);
        occ = 1 + s + t + h + p_r(d);
        @(posedge clk); #1;
        vld[d][ch] = 1'b1; wrb[d][ch] = wr; a0s[d][ch] = a0; wds[d][ch] = wd;
        din_s[d] = 16'hDEAD;
        @(negedge clk);
        chk("accept_ready", ch ? rdy1[d] : rdy0[d], 1);
        push_exp(d, cyc + s + t + 1, ch, !wr, din);
        @(posedge clk); #1;
        vld[d][ch] = 1'b0;
        for (int k = 1; k < occ; k++) begin
            in_act = (k <= s + t + h);
            strobe = (k > s) && (k <= s + t);
            din_s[d] = strobe ? din : 16'hDEAD;
            if (pulse_at != 0 && k == pulse_at) begin
                vld[d][!ch] = 1'b1; wrb[d][!ch] = 1'b1;
            end
            if (pulse_at != 0 && k == pulse_at + 1) vld[d][!ch] = 1'b0;
            @(negedge clk);
            exp_v = {!in_act, !(strobe && !wr), !(strobe && wr), wr && in_act, ch, a0, 2'b00};
            act_v = {cs_n[d], rd_n[d], wr_n[d], doe[d], addr[d], rdy1[d], rdy0[d]};
            chk($sformatf("bus d%0d k%0d", d, k), act_v, exp_v);
            if (wr && in_act) chk($sformatf("dout d%0d k%0d", d, k), dout[d], wd);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (doe[d] === 1'b1 && rd_n[d] === 1'b0) viol++;
            for (int ch = 0; ch < 2; ch++) begin
                logic        r;
                logic [15:0] rv;
                exp_t        e;
                r  = ch ? rsp1[d] : rsp0[d];
                rv = ch ? rdat1[d] : rdat0[d];
                if (r === 1'b1) begin
                    if ((d == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected: d%0d ch%0d rsp_valid=1 required 0 (cycle %0d)", d, ch, cyc);
                    end else begin
                        e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        chk("rsp_cycle", cyc, e.cyc);
                        chk("rsp_ch", ch, e.ch);
                        if (e.rd) chk("rsp_rdata", rv, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int  prev, found;
        bit  hi;
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; vld[d] = '0; wrb[d] = '0; a0s[d] = '0;
            wds[d][0] = '0; wds[d][1] = '0; din_s[d] = 16'hDEAD;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset d%0d", d),
                {cs_n[d], rd_n[d], wr_n[d], doe[d], addr[d], dout[d], rsp1[d], rsp0[d], rdat0[d], rdat1[d]},
                {4'b1110, 2'b00, 16'h0, 2'b00, 32'h0});
        @(posedge clk); #1;
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        // ch0 write, then ch1 read, then ch1 write with a stray ch0 pulse mid-transfer
        issue(0, 1'b0, 1'b1, 1'b1, 16'h00A5, 16'h0000, 0);
        issue(0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1362, 0);
        @(negedge clk);
        chk("rdata_after_read", rdat1[0], 16'h1362);
        issue(0, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 4);
        hi = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hi = hi && cs_n[0] && !rdy0[0];
        end
        chk("no_stray_cycle", hi, 1);
        chk("rdata_held_ch1", rdat1[0], 16'h1362);
        chk("rdata_ch0_untouched", rdat0[0], 16'h0000);

        // short timing: 1-cycle strobe, 8-cycle occupancy
        issue(1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h4321, 0);
        @(negedge clk);
        chk("short_rdata", rdat0[1], 16'h4321);

        // both requesters valid from reset: alternate grants, 13 cycles apart
        @(posedge clk); #1;
        rstn[0] = 1'b0; vld[0] = 2'b11; wrb[0] = 2'b11; a0s[0] = 2'b00;
        repeat (2) @(posedge clk);
        #1 rstn[0] = 1'b1;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (rdy0[0] || rdy1[0]) begin found = 1; break; end
            end
            chk("rr_found", found, 1);
            chk("rr_grant", {rdy1[0], rdy0[0]}, (i % 2) ? 2'b10 : 2'b01);
            if (prev >= 0) chk("rr_spacing", cyc - prev, 13);
            if (found != 0) push_exp(0, cyc + 6, rdy1[0], 1'b0, 16'h0);
            prev = cyc;
        end
        @(posedge clk); #1;
        vld[0] = 2'b00;
        repeat (15) @(posedge clk);
        #1;

        // reset during a write strobe aborts cleanly
        vld[0][0] = 1'b1; wrb[0][0] = 1'b1; a0s[0][0] = 1'b0; wds[0][0] = 16'h5A5A;
        @(posedge clk); #1;
        vld[0][0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pre_strobe", wr_n[0], 0);
        @(posedge clk); #1;
        rstn[0] = 1'b0;
        @(posedge clk); #1;
        rstn[0] = 1'b1;
        @(negedge clk);
        chk("abort_post", {cs_n[0], rd_n[0], wr_n[0], doe[0], rsp1[0], rsp0[0]}, 6'b111000);
        issue(0, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'h0000, 0);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sbq0.size() + sbq1.size(), 0);
        chk("doe_during_read", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/isp1362_bus_arbiter.md
Name: isp1362_bus_arbiter

Overview:
- Shares the single ISP1362 16-bit parallel bus between two requesters: ch0 = host-controller (HC) side, ch1 = device-controller (DC) side.
- Each accepted command becomes one bus cycle with programmable setup, strobe, hold and recovery timing on CS_N, RD_N and WR_N.
- Sits between the processor-side bridge logic and the OTG_* pins; the top level builds the OTG_DATA tristate from otg_dout and otg_doe.

Parameters:
- SETUP_CYC, 1, cycles with CS_N low and address valid before the strobe (1..255)
- STROBE_CYC, 4, cycles RD_N or WR_N is held low (1..255)
- HOLD_CYC, 1, cycles CS_N, address and write data are held after the strobe rises (1..255)
- RECOVER_CYC, 6, cycles CS_N is high before the next access (1..255)

Ports:
- CLOCK_50  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- c0_valid, c1_valid  in  1 each  command request
- c0_write, c1_write  in  1 each  1 = write, 0 = read
- c0_a0, c1_a0  in  1 each  ISP1362 A0 (1 = command port, 0 = data port)
- c0_wdata, c1_wdata  in  16 each  write data
- c0_ready, c1_ready  out  1 each  command accepted when valid && ready
- c0_rsp_valid, c1_rsp_valid  out  1 each  single-cycle completion pulse
- c0_rdata, c1_rdata  out  16 each  captured read data
- otg_addr  out  2  {A1 = channel index, A0}
- otg_cs_n, otg_rd_n, otg_wr_n  out  1 each  bus strobes
- otg_dout  out  16  write data to the pad
- otg_doe  out  1  pad output enable
- otg_din  in  16  data from the pad

Behaviour:
- Reset (rst_n low at an edge): state IDLE, otg_cs_n = otg_rd_n = otg_wr_n = 1, otg_addr = 0, otg_dout = 0, otg_doe = 0, rsp_valid = 0, rdata = 0, last_grant = 1 (so ch0 wins first). Reset mid-transfer aborts at the next edge; no rsp_valid is issued.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. One 8-bit down-counter, loaded on each state entry with (param − 1).
- IDLE: cX_ready = (state == IDLE) && grantX. This is combinational from state and both valids.
  - Only one valid: that channel is granted.
  - Both valid: the channel not equal to last_grant is granted (round-robin).
  - On the accept edge: latch write, a0, wdata and channel; update last_grant; go to SETUP. Ready is never high outside IDLE.
- SETUP: cs_n = 0, otg_addr = {ch, a0}, rd_n = wr_n = 1. For writes, doe = 1 and dout = wdata. Lasts SETUP_CYC cycles.
- STROBE: rd_n = 0 (read) or wr_n = 0 (write); other signals unchanged. Lasts STROBE_CYC cycles. For reads, otg_din is captured into the channel's rdata at the edge ending the last STROBE cycle.
- HOLD: strobes high, cs_n = 0, address, dout and doe held. rsp_valid of the owning channel is high for exactly the first HOLD cycle, for both reads and writes. Lasts HOLD_CYC cycles.
- RECOVER: cs_n = 1, doe = 0, addr held. Lasts RECOVER_CYC cycles, then IDLE.
- All otg_* outputs are registered and glitch-free. doe is never 1 while rd_n = 0.
- rdata holds its value until the next read on the same channel; writes do not alter it.
- Per-transaction occupancy is 1 + SETUP + STROBE + HOLD + RECOVER cycles (13 with defaults). Back-to-back accept edges are 13 cycles apart.
- Valid may deassert before it is accepted; no command is queued.

Decomposition:
- Package isp1362_bus_pkg holds:
  - the state enum
  - the default timing constants
  - A1 encodings (HC = 0, DC = 1)
  - the 8-bit counter width
- Sub-module isp1362_rr_arb: 2-way round-robin arbiter. Inputs are the two valids, last_grant and an enable (state == IDLE); outputs are grant0 and grant1.

Test Plan:
- Write on ch0, a0 = 1, wdata = 0x00A5:
  - ready at cycle 0; cs_n low cycles 1–12 minus recovery (cycles 1–6)
  - wr_n low cycles 2–5; addr = 2'b01; dout = 0x00A5 with doe = 1 cycles 1–6
  - c0_rsp_valid at cycle 6; cs_n high cycles 7–12
- Read on ch1, a0 = 0, otg_din = 0x1362 driven during the strobe:
  - rd_n low 4 cycles; addr = 2'b10; doe stays 0
  - c1_rdata = 0x1362 and c1_rsp_valid pulse in the first HOLD cycle
- Both valid continuously from reset: grants alternate ch0, ch1, ch0, ch1, with accept edges 13 cycles apart and no starvation.
- rst_n low during STROBE of a write: next edge gives cs_n = wr_n = 1, doe = 0, state IDLE, no rsp_valid; a fresh command then completes normally.
- Parameters SETUP = 2, STROBE = 1, HOLD = 3, RECOVER = 1: read strobe is 1 cycle wide, occupancy is 8 cycles, data is captured at the edge ending the strobe.
- c0_valid pulsed for one cycle while busy: not accepted; c0_ready stays 0 and no bus cycle is generated.
